// File: rtl/conn_pkg.sv
// conn_pkg: shared definitions for the connection-table aging scheduler.
//   - Entry layout {valid[16], evb[15:8], lastTMP[7:0]} field offsets.
//   - agingInfo layout {flowID[39:24], pad[23:16], evb[15:8], lastTMP[7:0]} offsets.
//   - Timestamp / flowID widths and aging scanner state encodings.
package conn_pkg;

    localparam int unsigned w_timestamp = 8;
    localparam int unsigned w_flowID    = 16;
    localparam int unsigned w_agingInfo = 40;

    typedef logic [w_timestamp-1:0] timestamp_t;

    // Entry field offsets
    localparam int unsigned ENT_VALID   = 16;
    localparam int unsigned ENT_EVB_MSB = 15;
    localparam int unsigned ENT_EVB_LSB = 8;
    localparam int unsigned ENT_TMP_MSB = 7;
    localparam int unsigned ENT_TMP_LSB = 0;

    // agingInfo field offsets
    localparam int unsigned AI_FLOW_LSB = 24;
    localparam int unsigned AI_PAD_LSB  = 16;
    localparam int unsigned AI_EVB_LSB  = 8;
    localparam int unsigned AI_TMP_LSB  = 0;

    // Aging scanner states
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRd   = 3'd1;
    localparam logic [2:0] StChk  = 3'd2;
    localparam logic [2:0] StWr   = 3'd3;
    localparam logic [2:0] StNext = 3'd4;

endpackage

// File: rtl/conn_aging_scheduler_if.sv
// conn_aging_scheduler_if: single-port connection-table RAM bus.
//   tb_rden / tb_wren  read / write enables (at most one set per cycle)
//   tb_addr            table address
//   tb_wdata           write data
//   tb_rdata           read data, valid one cycle after tb_rden
// Modports: master (scheduler side), slave (RAM side).
interface conn_aging_scheduler_if #(
    parameter int unsigned w_tbAddr = 10,
    parameter int unsigned w_entry  = 17
);

    logic                tb_rden;
    logic                tb_wren;
    logic [w_tbAddr-1:0] tb_addr;
    logic [w_entry-1:0]  tb_wdata;
    logic [w_entry-1:0]  tb_rdata;

    modport master (
        output tb_rden,
        output tb_wren,
        output tb_addr,
        output tb_wdata,
        input  tb_rdata
    );

    modport slave (
        input  tb_rden,
        input  tb_wren,
        input  tb_addr,
        input  tb_wdata,
        output tb_rdata
    );

endinterface

// File: rtl/aging_check.sv
// aging_check: combinational age comparator.
//   valid          entry valid bit
//   last_tmp       entry last-seen timestamp
//   cur_timestamp  free-running timestamp
//   cfg_ageThresh  threshold; 0 disables aging
//   expired        entry is valid and (cur - last) mod 256 >= threshold
module aging_check
    import conn_pkg::*;
(
    input  logic       valid,
    input  timestamp_t last_tmp,
    input  timestamp_t cur_timestamp,
    input  timestamp_t cfg_ageThresh,
    output logic       expired
);

    timestamp_t age;

    always_comb begin
        // Modular subtraction handles timestamp wrap.
        age     = cur_timestamp - last_tmp;
        expired = valid && (cfg_ageThresh != '0) && (age >= cfg_ageThresh);
    end

endmodule

// File: rtl/conn_aging_scheduler.sv
// conn_aging_scheduler: shares the single-port connection table between the
// searcher (always wins) and a background aging scanner that invalidates
// timed-out entries and reports each one as a 40-bit agingInfo word.
// Ports:
//   clk, reset (async, active-low)
//   cur_timestamp, cfg_ageThresh    aging inputs
//   scan_start                      pulse; starts a sweep when idle
//   srch_req/wr/addr/wdata          searcher access
//   srch_rdata_valid, srch_rdata    searcher read return (1 cycle later)
//   tbl                             table RAM bus (master modport)
//   agingInfo_alf                   aging buffer almost-full
//   agingInfo_valid, agingInfo      aging report strobe and word
//   scan_busy                       sweep in progress
// Build option: AGING_STARVE_GUARD_EN forces a scanner slot after
// STARVE_LIMIT consecutive denied cycles (searcher stalls one cycle).
module conn_aging_scheduler
    import conn_pkg::*;
#(
    parameter int unsigned w_tbAddr     = 10,
    parameter int unsigned w_entry      = 17,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  timestamp_t             cur_timestamp,
    input  timestamp_t             cfg_ageThresh,
    input  logic                   scan_start,
    input  logic                   srch_req,
    input  logic                   srch_wr,
    input  logic [w_tbAddr-1:0]    srch_addr,
    input  logic [w_entry-1:0]     srch_wdata,
    output logic                   srch_rdata_valid,
    output logic [w_entry-1:0]     srch_rdata,
    conn_aging_scheduler_if.master tbl,
    input  logic                   agingInfo_alf,
    output logic                   agingInfo_valid,
    output logic [w_agingInfo-1:0] agingInfo,
    output logic                   scan_busy
);

    logic [2:0]             state_q, state_d;
    logic [w_tbAddr-1:0]    scan_addr_q, scan_addr_d;
    logic [w_entry-1:0]     ent_q, ent_d;
    logic                   rvalid_q;
    logic                   ai_valid_q;
    logic [w_agingInfo-1:0] ai_q;

    logic force_slot;
    logic srch_take;
    logic scan_rd;
    logic scan_wr;
    logic hazard;
    logic expired;

`ifdef AGING_STARVE_GUARD_EN
    localparam int unsigned w_starve = $clog2(STARVE_LIMIT + 1);
    logic [w_starve-1:0] starve_q;
    logic                denied;

    assign force_slot = (starve_q == w_starve'(STARVE_LIMIT));
    assign denied     = ((state_q == StRd) || (state_q == StWr)) && srch_req && !force_slot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else if (scan_rd || scan_wr) begin
            starve_q <= '0;
        end else if (denied) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_slot          = 1'b0;
`endif

    // A forced scanner slot drops the searcher request for that cycle.
    assign srch_take = srch_req && !force_slot;
    assign scan_rd   = (state_q == StRd) && !srch_take;
    assign scan_wr   = (state_q == StWr) && !srch_take;
    // Searcher refresh of the entry under inspection invalidates our copy.
    assign hazard    = srch_take && srch_wr && (srch_addr == scan_addr_q);

    aging_check u_aging_check (
        .valid         (tbl.tb_rdata[ENT_VALID]),
        .last_tmp      (tbl.tb_rdata[ENT_TMP_MSB:ENT_TMP_LSB]),
        .cur_timestamp (cur_timestamp),
        .cfg_ageThresh (cfg_ageThresh),
        .expired       (expired)
    );

    always_comb begin
        tbl.tb_rden  = srch_take ? !srch_wr : scan_rd;
        tbl.tb_wren  = srch_take ? srch_wr : scan_wr;
        tbl.tb_addr  = srch_take ? srch_addr : scan_addr_q;
        tbl.tb_wdata = srch_take ? srch_wdata : {1'b0, ent_q[ENT_EVB_MSB:ENT_TMP_LSB]};
    end

    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        ent_d       = ent_q;
        case (state_q)
            StIdle: if (scan_start) state_d = StRd;
            StRd:   if (scan_rd) state_d = StChk;
            StChk: begin
                ent_d = tbl.tb_rdata;
                if (hazard) begin
                    state_d = StRd;
                end else if (expired) begin
                    state_d = agingInfo_alf ? StRd : StWr;
                end else begin
                    state_d = StNext;
                end
            end
            StWr: begin
                if (hazard) begin
                    state_d = StRd;
                end else if (scan_wr) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (scan_addr_q == '1) begin
                    scan_addr_d = '0;
                    state_d     = StIdle;
                end else begin
                    scan_addr_d = scan_addr_q + 1'b1;
                    state_d     = StRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            scan_addr_q <= '0;
            ent_q       <= '0;
            rvalid_q    <= 1'b0;
            ai_valid_q  <= 1'b0;
            ai_q        <= '0;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            ent_q       <= ent_d;
            rvalid_q    <= srch_take && !srch_wr;
            ai_valid_q  <= scan_wr;
            if (scan_wr) begin
                ai_q <= {w_flowID'(scan_addr_q), 8'h00, ent_q[ENT_EVB_MSB:ENT_TMP_LSB]};
            end
        end
    end

    assign srch_rdata_valid = rvalid_q;
    assign srch_rdata       = rvalid_q ? tbl.tb_rdata : '0;
    assign agingInfo_valid  = ai_valid_q;
    assign agingInfo        = ai_q;
    assign scan_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_conn_aging_scheduler.sv
// Bench for conn_aging_scheduler: RAM model, per-cycle checker against a
// sweep-level model (which entries must age, in what order, with what word),
// directed scenarios plus randomized searcher reads and backpressure.
module tb_conn_aging_scheduler;
    import conn_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned EW = 17;
    localparam int unsigned N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    cur_timestamp = 8'h00;
    logic [7:0]    cfg_ageThresh = 8'h00;
    logic          scan_start = 1'b0;
    logic          srch_req = 1'b0;
    logic          srch_wr = 1'b0;
    logic [AW-1:0] srch_addr = '0;
    logic [EW-1:0] srch_wdata = '0;
    logic          srch_rdata_valid;
    logic [EW-1:0] srch_rdata;
    logic          agingInfo_alf = 1'b0;
    logic          agingInfo_valid;
    logic [39:0]   agingInfo;
    logic          scan_busy;

    conn_aging_scheduler_if #(.w_tbAddr(AW), .w_entry(EW)) tbus ();

    conn_aging_scheduler #(.w_tbAddr(AW), .w_entry(EW), .STARVE_LIMIT(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .cur_timestamp    (cur_timestamp),
        .cfg_ageThresh    (cfg_ageThresh),
        .scan_start       (scan_start),
        .srch_req         (srch_req),
        .srch_wr          (srch_wr),
        .srch_addr        (srch_addr),
        .srch_wdata       (srch_wdata),
        .srch_rdata_valid (srch_rdata_valid),
        .srch_rdata       (srch_rdata),
        .tbl              (tbus),
        .agingInfo_alf    (agingInfo_alf),
        .agingInfo_valid  (agingInfo_valid),
        .agingInfo        (agingInfo),
        .scan_busy        (scan_busy)
    );

    always #5 clk = ~clk;

    // Single-port table RAM, 1-cycle read latency.
    logic [EW-1:0] ram [N];
    always @(posedge clk) begin
        if (tbus.tb_wren) ram[tbus.tb_addr] <= tbus.tb_wdata;
        if (tbus.tb_rden) tbus.tb_rdata <= ram[tbus.tb_addr];
    end

    // Sweep-level model state
    bit            exp_aged [N];
    bit            wrote [N];
    bit            emitted [N];
    logic [EW-1:0] exp_mem [N];
    int            n_emit = 0;
    int            last_emit = -1;
    logic [39:0]   last_info = '0;
    int            checks = 0;
    int            errors = 0;
    bit            rnd_srch = 0;
    bit            rnd_alf = 0;

    function automatic bit model_aged(logic [16:0] e, int cur, int thr);
        int age;
        age = (cur - int'(e[7:0]) + 256) % 256;
        return e[16] && (thr != 0) && (age >= thr);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setup_sweep(int cur, int thr);
        cur_timestamp = 8'(cur);
        cfg_ageThresh = 8'(thr);
        for (int a = 0; a < N; a++) begin
            exp_mem[a]  = ram[a];
            exp_aged[a] = model_aged(ram[a], cur, thr);
            wrote[a]    = 0;
            emitted[a]  = 0;
        end
        n_emit    = 0;
        last_emit = -1;
    endtask

    task automatic clear_ram();
        for (int a = 0; a < N; a++) ram[a] = '0;
    endtask

    task automatic start_scan();
        @(posedge clk); #1 scan_start = 1'b1;
        @(posedge clk); #1 scan_start = 1'b0;
        chk("busy_rise", scan_busy, 1);
    endtask

    task automatic finish_sweep();
        int cyc;
        int nbad;
        int naged;
        cyc = 0;
        while (scan_busy && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sweep_done", scan_busy, 0);
        @(negedge clk);
        nbad  = 0;
        naged = 0;
        for (int a = 0; a < N; a++) begin
            logic [EW-1:0] e;
            e = exp_aged[a] ? {1'b0, exp_mem[a][15:0]} : exp_mem[a];
            if (exp_aged[a]) naged++;
            if (ram[a] !== e) nbad++;
        end
        chk("final_table_bad_entries", nbad, 0);
        chk("emit_count", n_emit, naged);
    endtask

    // Per-cycle checker
    bit            prev_rd = 0;
    logic [EW-1:0] prev_data = '0;
    always @(negedge clk) begin
        int a;
        if (!reset) begin
            prev_rd = 0;
        end else begin
            chk("rdata_valid", srch_rdata_valid, prev_rd);
            if (prev_rd) chk("rdata", srch_rdata, prev_data);
            if (srch_req) begin
                chk("prio_rden", tbus.tb_rden, !srch_wr);
                chk("prio_wren", tbus.tb_wren, srch_wr);
                chk("prio_addr", tbus.tb_addr, srch_addr);
                if (srch_wr) chk("prio_wdata", tbus.tb_wdata, srch_wdata);
            end else begin
                if (!scan_busy) chk("idle_access", {tbus.tb_rden, tbus.tb_wren}, 2'b00);
                if (tbus.tb_wren) begin
                    a = int'(tbus.tb_addr);
                    chk("scan_wr_allowed", {exp_aged[a], wrote[a]}, 2'b10);
                    chk("scan_wdata", tbus.tb_wdata, {1'b0, exp_mem[a][15:0]});
                    wrote[a] = 1;
                end
            end
            if (agingInfo_valid) begin
                a = int'(agingInfo[33:24]);
                chk("info_word", agingInfo, {6'b0, agingInfo[33:24], 8'h00, exp_mem[a][15:0]});
                chk("info_once", {exp_aged[a], wrote[a], emitted[a]}, 3'b110);
                chk("info_order", a > last_emit, 1);
                emitted[a] = 1;
                n_emit++;
                last_emit = a;
                last_info = agingInfo;
            end
            prev_rd   = srch_req && !srch_wr;
            prev_data = ram[srch_addr];
        end
    end

    // Background random searcher reads and backpressure
    always @(posedge clk) begin
        #1;
        if (rnd_srch) begin
            srch_req  = ($urandom_range(0, 99) < 30);
            srch_wr   = 1'b0;
            srch_addr = AW'($urandom_range(0, N - 1));
        end
        if (rnd_alf) agingInfo_alf = $urandom_range(0, 1) == 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        clear_ram();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata_valid", srch_rdata_valid, 0);
        chk("rst_rdata", srch_rdata, 0);
        chk("rst_info_valid", agingInfo_valid, 0);
        chk("rst_info", agingInfo, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_rden", tbus.tb_rden, 0);
        chk("rst_wren", tbus.tb_wren, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Pin the model's age arithmetic
        chk("model_wrap_aged", model_aged(17'h1_22FA, 8'h04, 8'h0A), 1);
        chk("model_wrap_not_aged", model_aged(17'h1_22FA, 8'h04, 8'h0B), 0);
        chk("model_thr0", model_aged(17'h1_0310, 8'h30, 8'h00), 0);

        // Only entry 5 aged
        clear_ram();
        ram[5] = 17'h1_0310;
        setup_sweep(8'h30, 8'h10);
        start_scan();
        finish_sweep();
        chk("t1_count", n_emit, 1);
        chk("t1_info", last_info, 40'h0005_00_03_10);
        chk("t1_entry5", ram[5], 17'h0_0310);

        // Timestamp wrap, just aged and just not aged
        clear_ram();
        ram[7] = 17'h1_22FA;
        setup_sweep(8'h04, 8'h0A);
        start_scan();
        finish_sweep();
        chk("wrap_count_aged", n_emit, 1);
        chk("wrap_info", last_info, 40'h0007_00_22_FA);
        ram[7] = 17'h1_22FA;
        setup_sweep(8'h04, 8'h0B);
        start_scan();
        finish_sweep();
        chk("wrap_count_not_aged", n_emit, 0);
        chk("wrap_entry_kept", ram[7], 17'h1_22FA);

        // Randomized sweeps with searcher reads and backpressure
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < N; a++) ram[a] = EW'($urandom);
            setup_sweep($urandom_range(0, 255), $urandom_range(1, 255));
            start_scan();
            rnd_srch = 1;
            rnd_alf  = 1;
            repeat (200) @(posedge clk);
            #2 scan_start = 1'b1;   // must be ignored while busy
            @(posedge clk); #2 scan_start = 1'b0;
            finish_sweep();
            rnd_srch = 0;
            rnd_alf  = 0;
            @(posedge clk); #2;
            srch_req      = 1'b0;
            agingInfo_alf = 1'b0;
        end

        // Searcher held for 100 cycles mid-sweep; threshold 0 ages nothing
        for (int a = 0; a < N; a++) ram[a] = EW'($urandom);
        setup_sweep($urandom_range(0, 255), 0);
        start_scan();
        repeat (500) @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            #1;
            srch_req  = 1'b1;
            srch_wr   = 1'b0;
            srch_addr = AW'($urandom_range(0, N - 1));
            @(posedge clk);
        end
        #1 srch_req = 1'b0;
        finish_sweep();
        chk("thr0_count", n_emit, 0);

        // Hazard: searcher refresh while the scanner is checking entry 9
        clear_ram();
        ram[9] = 17'h1_0310;
        setup_sweep(8'h30, 8'h10);
        start_scan();
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (tbus.tb_rden && !srch_req && tbus.tb_addr == 9) found = 1;
        end
        chk("hazard_read_seen", found, 1);
        @(posedge clk); #1;
        srch_req    = 1'b1;
        srch_wr     = 1'b1;
        srch_addr   = 10'd9;
        srch_wdata  = {1'b1, 8'h01, 8'h30};
        exp_aged[9] = 0;
        exp_mem[9]  = {1'b1, 8'h01, 8'h30};
        @(posedge clk); #1;
        srch_req = 1'b0;
        srch_wr  = 1'b0;
        finish_sweep();
        chk("hazard_count", n_emit, 0);
        chk("hazard_entry", ram[9], 17'h1_0130);

        // Backpressure holds the scanner at an aged entry
        clear_ram();
        ram[5] = 17'h1_0310;
        setup_sweep(8'h30, 8'h10);
        agingInfo_alf = 1'b1;
        start_scan();
        repeat (300) @(posedge clk);
        #1;
        chk("bp_no_output", n_emit, 0);
        chk("bp_still_busy", scan_busy, 1);
        chk("bp_entry_kept", ram[5], 17'h1_0310);
        agingInfo_alf = 1'b0;
        finish_sweep();
        chk("bp_count", n_emit, 1);
        chk("bp_info", last_info, 40'h0005_00_03_10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
